// File: rtl/hex_display_pkg.sv
// ============================================================================
// Module : hex_display_pkg
// Brief  : Register map, CTRL layout and helpers for the hex display block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_display_pkg;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_CTRL      = 2'd1;
    localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
    localparam logic [1:0] ADDR_STATUS    = 2'd3;

    localparam int NUM_DIGITS      = 6;
    localparam int CTRL_BLANK_LSB  = 0;
    localparam int CTRL_BLINK_LSB  = 8;
    localparam int CTRL_SCROLL_BIT = 16;
    localparam int CTRL_EN_BIT     = 31;

    typedef struct packed {
        logic                  en;
        logic                  scroll;
        logic [NUM_DIGITS-1:0] blink;
        logic [NUM_DIGITS-1:0] blank;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{en: 1'b1, scroll: 1'b0, blink: 6'd0, blank: 6'd0};

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w                                  = '0;
        w[CTRL_EN_BIT]                     = c.en;
        w[CTRL_SCROLL_BIT]                 = c.scroll;
        w[CTRL_BLINK_LSB +: NUM_DIGITS]    = c.blink;
        w[CTRL_BLANK_LSB +: NUM_DIGITS]    = c.blank;
        return w;
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.en     = w[CTRL_EN_BIT];
        c.scroll = w[CTRL_SCROLL_BIT];
        c.blink  = w[CTRL_BLINK_LSB +: NUM_DIGITS];
        c.blank  = w[CTRL_BLANK_LSB +: NUM_DIGITS];
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_display_regs_tick_gen.sv
// ============================================================================
// Module : hex_tick_gen
// Brief  : Blink prescaler; ticks every div+1 cycles and toggles the phase.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_tick_gen #(
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             tick,
    output logic             phase
);

    localparam logic [DIV_W-1:0] RESET_COUNT = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] r_count;
    logic             r_phase;
    logic             w_div_zero;
    logic             w_count_zero;

    assign w_div_zero   = (div == '0);
    assign w_count_zero = (r_count == '0);
    // A reload from the bus suppresses a tick landing in the same cycle.
    assign tick         = !load && !w_div_zero && w_count_zero;
    assign phase        = r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= RESET_COUNT;
            r_phase <= 1'b1;
        end else if (load) begin
            r_count <= div;
            r_phase <= 1'b1;
        end else if (w_div_zero) begin
            r_count <= '0;
            r_phase <= 1'b1;
        end else if (w_count_zero) begin
            r_count <= div;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hex_display_regs.sv
// ============================================================================
// Module : hex_display_regs
// Brief  : Avalon-MM register block driving six seven-segment digits with
//          per-digit blank/blink. Optional digit scroll when HEX_SCROLL_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_display_regs #(
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [23:0] pio_7_seg,
    output logic [5:0]  hex_blank
);

    import hex_display_pkg::*;

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    logic [23:0]      r_data;
    ctrl_t            r_ctrl;
    logic [DIV_W-1:0] r_blink_div;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;
    logic [23:0]      r_pio;
    logic [5:0]       r_hex_blank;

    logic             w_wr_data;
    logic             w_wr_ctrl;
    logic             w_wr_div;
    logic [DIV_W-1:0] w_div_next;
    logic             w_tick;
    logic             w_phase;
    logic [31:0]      w_rdata;
    ctrl_t            w_ctrl_wr;

    assign w_wr_data  = avs_write && (avs_address == ADDR_DATA);
    assign w_wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign w_wr_div   = avs_write && (avs_address == ADDR_BLINK_DIV);
    assign w_div_next = w_wr_div ? avs_writedata[DIV_W-1:0] : r_blink_div;

    always_comb begin
        w_ctrl_wr = word_to_ctrl(avs_writedata);
`ifndef HEX_SCROLL_EN
        w_ctrl_wr.scroll = 1'b0;
`endif
    end

    hex_tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .div   (w_div_next),
        .load  (w_wr_div),
        .tick  (w_tick),
        .phase (w_phase)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data      <= '0;
            r_ctrl      <= CTRL_RESET;
            r_blink_div <= RESET_DIV;
        end else begin
            if (w_wr_data) begin
                r_data <= avs_writedata[23:0];
            end
`ifdef HEX_SCROLL_EN
            // Bus write to DATA takes priority over a coincident rotate.
            else if (w_tick && r_ctrl.scroll) begin
                r_data <= {r_data[19:0], r_data[23:20]};
            end
`endif
            if (w_wr_ctrl) begin
                r_ctrl <= w_ctrl_wr;
            end
            if (w_wr_div) begin
                r_blink_div <= w_div_next;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            ADDR_DATA:      w_rdata[23:0]      = r_data;
            ADDR_CTRL:      w_rdata            = ctrl_to_word(r_ctrl);
            ADDR_BLINK_DIV: w_rdata[DIV_W-1:0] = r_blink_div;
            ADDR_STATUS:    w_rdata[0]         = w_phase;
            default:        w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            r_pio           <= '0;
            r_hex_blank     <= '0;
        end else begin
            r_readdatavalid <= avs_read;
            if (avs_read) begin
                r_readdata <= w_rdata;
            end
            r_pio       <= r_data;
            r_hex_blank <= {NUM_DIGITS{~r_ctrl.en}} | r_ctrl.blank
                           | (r_ctrl.blink & {NUM_DIGITS{~w_phase}});
        end
    end

    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_readdatavalid;
    assign pio_7_seg         = r_pio;
    assign hex_blank         = r_hex_blank;

endmodule

`default_nettype wire
